apb_io_bank: RTL and testbench
==============================

Name: apb_io_bank

Overview:
Parametrised APB slave holding NUM_OUT read/write output registers (LED, segment display, etc.) and NUM_IN input channels (switches). Each input channel passes through a 2-flop synchroniser and a per-channel debouncer. A change in any debounced input raises a maskable, level interrupt. The block sits on the peripheral APB bus at BASE_ADDR and generalises the fixed LED/SW1/SW2/SEG peripheral.

Parameters:
BASE_ADDR, 32'h2000_0000, byte base address of the block; 4 KB window.
DW, 32, width of every data channel (1..32).
NUM_OUT, 2, number of output registers (1..64).
NUM_IN, 2, number of input channels (1..32).
OUT0_RST, 32'hFF00_FF00, reset value of output register 0; all other output registers reset to 0.
DB_CYCLES, 16, debounce qualification length in Pclk cycles (1..65535).

Ports:
Pclk  in  1  APB clock
Prst  in  1  reset, asynchronous, active-high
Paddr  in  32  APB address
Pwrite  in  1  1 = write
Psel  in  1  slave select
Penable  in  1  access phase
Pwdata  in  32  write data
Prdata  out  32  read data
Pready  out  1  tied 1; no wait states
Pslverr  out  1  error response
out_data  out  NUM_OUT*DW  output registers, channel i at [i*DW +: DW]
in_data  in  NUM_IN*DW  raw asynchronous inputs, channel j at [j*DW +: DW]
irq  out  1  level interrupt

Behaviour:
- Address decode: off = Paddr - BASE_ADDR. Valid only when off < 0x1000 and off[1:0] == 0.
- Register map:
  - 0x000+4i: OUT[i], RW, for i < NUM_OUT.
  - 0x100+4j: IN[j], RO, debounced value, for j < NUM_IN.
  - 0x200: INT_STATUS, bits [NUM_IN-1:0], write-1-to-clear.
  - 0x204: INT_EN, RW, bits [NUM_IN-1:0].
  - 0x208: ID, RO = {NUM_OUT[7:0], NUM_IN[7:0], 16'hA510}.
- Bus timing:
  - Write commits on the Pclk edge where Psel & Penable & Pwrite.
  - Prdata is combinational. During Psel & !Pwrite it carries the selected register, zero-extended from DW. Otherwise Prdata = 0.
  - Pready = 1 at all times.
- Pslverr = Psel & Penable & err. err is set for any of:
  - unmapped or unaligned offset;
  - write to IN[j] or ID;
  - access to OUT index >= NUM_OUT or IN index >= NUM_IN.
  - On error, writes are ignored and Prdata = 0.
- Write width: only Pwdata[DW-1:0] is stored. Upper bits are ignored, and register bits above DW read 0.
- Reset (Prst=1, async):
  - OUT[0] = OUT0_RST[DW-1:0]; other OUT = 0.
  - Sync flops, stable values and debounce counters = 0.
  - INT_STATUS = 0, INT_EN = 0, irq = 0.
  - Reset mid-transfer aborts the transfer with no write committed.
- Synchroniser: two flops per channel; sync[j] lags in_data by 2 cycles.
- Debouncer, per channel j, with 16-bit counter cnt[j] and register stable[j]:
  - If sync[j] == stable[j]: cnt <= 0.
  - Else if cnt == DB_CYCLES-1: stable <= sync, cnt <= 0, chg[j] pulses for 1 cycle.
  - Else: cnt <= cnt + 1.
  - Any glitch that returns sync to stable before qualification restarts the count.
  - A value that keeps changing while it differs from stable does not restart the count. Qualification is on "differs", not on "equal value".
  - Latency from in_data change to IN[j] update = 2 + DB_CYCLES cycles. With DB_CYCLES = 1 that is 3 cycles.
- Interrupts:
  - chg[j] sets INT_STATUS[j] on the next edge.
  - A W1C write clears the bits where Pwdata = 1.
  - If a set and a clear of the same bit land in the same cycle, the set wins.
  - irq = |(INT_STATUS & INT_EN), registered, so it lags the status bit by 1 cycle.
  - INT_STATUS sets regardless of INT_EN. Enabling while a status bit is pending raises irq 1 cycle after the INT_EN write.
- Post-reset inputs: inputs held nonzero through reset qualify DB_CYCLES+2 cycles after release and set INT_STATUS. INT_EN resets to 0, so no irq fires until software enables it.

Test Plan:
1. Reset: read 0x000 returns 0xFF00FF00; read 0x004 returns 0; read 0x208 returns 0x0202A510; irq = 0; Pslverr = 0.
2. Output write: write 0x12345678 to 0x004, then read back 0x12345678; out_data[63:32] = 0x12345678 on the cycle after the access phase.
3. Debounce: DB_CYCLES = 16, in_data ch0 changes 0 → 0xA5. IN[0] reads 0 through cycle 17 after the change and 0xA5 from cycle 18. A 5-cycle 0xA5 pulse never updates IN[0].
4. Interrupts: with INT_EN = 0x1, qualify a change on ch0 → INT_STATUS = 0x1 and irq = 1 one cycle later. W1C 0x1 → irq = 0. A W1C of 0x1 in the same cycle as a new chg[0] leaves INT_STATUS = 0x1.
5. Errors: write to 0x100, 0x00C (NUM_OUT = 2), 0x002 or 0x300 → Pslverr = 1 in the access phase and no register changes. A read of 0x300 returns 0 with Pslverr = 1.
6. Async reset: assert Prst mid-write-access to 0x000 → OUT[0] = 0xFF00FF00 immediately and the write is not committed.

Source files
------------

// File: rtl/apb_io_bank_if.sv
// APB bus bundle for apb_io_bank: master drives address/control/write data,
// slave returns read data, ready and error.
interface apb_io_bank_if;
  logic [31:0] Paddr;
  logic        Pwrite;
  logic        Psel;
  logic        Penable;
  logic [31:0] Pwdata;
  logic [31:0] Prdata;
  logic        Pready;
  logic        Pslverr;

  modport master (
    output Paddr, Pwrite, Psel, Penable, Pwdata,
    input  Prdata, Pready, Pslverr
  );

  modport slave (
    input  Paddr, Pwrite, Psel, Penable, Pwdata,
    output Prdata, Pready, Pslverr
  );
endinterface

// File: rtl/apb_io_bank.sv
// APB I/O bank: NUM_OUT read/write output registers and NUM_IN synchronised,
// debounced input channels with a maskable level interrupt on any change.
module apb_io_bank #(
  parameter logic [31:0] BASE_ADDR = 32'h2000_0000,
  parameter int          DW        = 32,
  parameter int          NUM_OUT   = 2,
  parameter int          NUM_IN    = 2,
  parameter logic [31:0] OUT0_RST  = 32'hFF00_FF00,
  parameter int          DB_CYCLES = 16
) (
  input  logic                   Pclk,
  input  logic                   Prst,
  apb_io_bank_if.slave           bus,
  output logic [NUM_OUT*DW-1:0]  out_data,
  input  logic [NUM_IN*DW-1:0]   in_data,
  output logic                   irq
);

  localparam logic [15:0] DB_LAST = 16'(DB_CYCLES - 1);
  localparam logic [31:0] ID_VAL  = {8'(NUM_OUT), 8'(NUM_IN), 16'hA510};

  function automatic logic [31:0] zext(input logic [DW-1:0] v);
    logic [31:0] r;
    r = '0;
    r[DW-1:0] = v;
    return r;
  endfunction

  logic [DW-1:0]        out_q    [NUM_OUT];
  logic [DW-1:0]        out_d    [NUM_OUT];
  logic [NUM_IN*DW-1:0] sync1_q, sync1_d, sync2_q, sync2_d;
  logic [DW-1:0]        stable_q [NUM_IN];
  logic [DW-1:0]        stable_d [NUM_IN];
  logic [15:0]          cnt_q    [NUM_IN];
  logic [15:0]          cnt_d    [NUM_IN];
  logic [NUM_IN-1:0]    chg;
  logic [NUM_IN-1:0]    st_q, st_d, en_q, en_d, clr;
  logic                 irq_q, irq_d;

  logic [31:0] off;
  logic [5:0]  idx;
  logic        sel_out, sel_in, sel_st, sel_en, sel_id, err, wr_fire;
  logic [31:0] rd;

  // Address decode: classify the offset and flag illegal accesses.
  always_comb begin
    off     = bus.Paddr - BASE_ADDR;
    idx     = off[7:2];
    sel_out = 1'b0;
    sel_in  = 1'b0;
    sel_st  = 1'b0;
    sel_en  = 1'b0;
    sel_id  = 1'b0;
    if (off < 32'h1000 && off[1:0] == 2'b00) begin
      if (off[11:8] == 4'h0)        sel_out = int'(idx) < NUM_OUT;
      else if (off[11:8] == 4'h1)   sel_in  = int'(idx) < NUM_IN;
      else if (off[11:0] == 12'h200) sel_st = 1'b1;
      else if (off[11:0] == 12'h204) sel_en = 1'b1;
      else if (off[11:0] == 12'h208) sel_id = 1'b1;
    end
    err     = !(sel_out || sel_st || sel_en ||
                ((sel_in || sel_id) && !bus.Pwrite));
    wr_fire = bus.Psel && bus.Penable && bus.Pwrite && !err;
  end

  // Combinational read mux; only driven while a read is selected and legal.
  always_comb begin
    rd = '0;
    if (sel_out) begin
      for (int i = 0; i < NUM_OUT; i++)
        if (idx == 6'(i)) rd = zext(out_q[i]);
    end
    if (sel_in) begin
      for (int j = 0; j < NUM_IN; j++)
        if (idx == 6'(j)) rd = zext(stable_q[j]);
    end
    if (sel_st) rd[NUM_IN-1:0] = st_q;
    if (sel_en) rd[NUM_IN-1:0] = en_q;
    if (sel_id) rd = ID_VAL;
    bus.Prdata  = (bus.Psel && !bus.Pwrite && !err) ? rd : '0;
    bus.Pready  = 1'b1;
    bus.Pslverr = bus.Psel && bus.Penable && err;
  end

  // Next-state for output registers, interrupt enable/status and irq.
  always_comb begin
    for (int i = 0; i < NUM_OUT; i++) begin
      out_d[i] = out_q[i];
      if (wr_fire && sel_out && idx == 6'(i)) out_d[i] = bus.Pwdata[DW-1:0];
    end
    en_d = en_q;
    if (wr_fire && sel_en) en_d = bus.Pwdata[NUM_IN-1:0];
    clr = (wr_fire && sel_st) ? bus.Pwdata[NUM_IN-1:0] : '0;
    // A fresh change overrides a same-cycle clear.
    st_d  = (st_q & ~clr) | chg;
    irq_d = |(st_q & en_q);
  end

  // Synchroniser chain and per-channel debounce; counting runs while the
  // synchronised value differs from the stable one, whatever that value is.
  always_comb begin
    sync1_d = in_data;
    sync2_d = sync1_q;
    chg     = '0;
    for (int j = 0; j < NUM_IN; j++) begin
      stable_d[j] = stable_q[j];
      cnt_d[j]    = cnt_q[j];
      if (sync2_q[j*DW +: DW] == stable_q[j]) begin
        cnt_d[j] = '0;
      end else if (cnt_q[j] == DB_LAST) begin
        stable_d[j] = sync2_q[j*DW +: DW];
        cnt_d[j]    = '0;
        chg[j]      = 1'b1;
      end else begin
        cnt_d[j] = cnt_q[j] + 16'd1;
      end
    end
  end

  // Output register bank.
  always_ff @(posedge Pclk or posedge Prst) begin
    if (Prst) begin
      for (int i = 0; i < NUM_OUT; i++)
        out_q[i] <= (i == 0) ? OUT0_RST[DW-1:0] : '0;
    end else begin
      for (int i = 0; i < NUM_OUT; i++) out_q[i] <= out_d[i];
    end
  end

  // Input synchroniser and debounce state.
  always_ff @(posedge Pclk or posedge Prst) begin
    if (Prst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      for (int j = 0; j < NUM_IN; j++) begin
        stable_q[j] <= '0;
        cnt_q[j]    <= '0;
      end
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      for (int j = 0; j < NUM_IN; j++) begin
        stable_q[j] <= stable_d[j];
        cnt_q[j]    <= cnt_d[j];
      end
    end
  end

  // Interrupt status, enable and registered irq.
  always_ff @(posedge Pclk or posedge Prst) begin
    if (Prst) begin
      st_q  <= '0;
      en_q  <= '0;
      irq_q <= 1'b0;
    end else begin
      st_q  <= st_d;
      en_q  <= en_d;
      irq_q <= irq_d;
    end
  end

  for (genvar g = 0; g < NUM_OUT; g++) begin : g_out
    assign out_data[g*DW +: DW] = out_q[g];
  end

  assign irq = irq_q;

endmodule

// File: tb/tb_apb_io_bank.sv
// Directed bench for apb_io_bank: register-map vector table followed by
// hand-timed debounce, interrupt and asynchronous reset sequences.
module tb_apb_io_bank;
  localparam logic [31:0] BASE = 32'h2000_0000;

  logic        Pclk = 1'b0;
  logic        Prst;
  logic [63:0] out_data;
  logic [63:0] in_data;
  logic        irq;

  apb_io_bank_if bus();

  apb_io_bank #(
    .BASE_ADDR(BASE), .DW(32), .NUM_OUT(2), .NUM_IN(2),
    .OUT0_RST(32'hFF00_FF00), .DB_CYCLES(16)
  ) dut (
    .Pclk(Pclk), .Prst(Prst), .bus(bus),
    .out_data(out_data), .in_data(in_data), .irq(irq)
  );

  always #5 Pclk = ~Pclk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One complete APB transfer; rdata/err captured in the access phase.
  task automatic xfer(input logic wr, input logic [31:0] off, input logic [31:0] wdata,
                      output logic [31:0] rdata, output logic err);
    @(posedge Pclk); #1;
    bus.Psel = 1'b1; bus.Penable = 1'b0; bus.Pwrite = wr;
    bus.Paddr = BASE + off; bus.Pwdata = wdata;
    @(posedge Pclk); #1;
    bus.Penable = 1'b1;
    #1;
    rdata = bus.Prdata;
    err   = bus.Pslverr;
    @(posedge Pclk); #1;
    bus.Psel = 1'b0; bus.Penable = 1'b0; bus.Pwrite = 1'b0;
  endtask

  typedef struct {
    logic        wr;
    logic [31:0] off;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_err;
    string       name;
  } vec_t;

  vec_t tbl[$];

  initial begin
    logic [31:0] rd;
    logic        er;

    tbl.push_back('{1'b0, 32'h000, 32'h0,        32'hFF00FF00, 1'b0, "rst_out0"});
    tbl.push_back('{1'b0, 32'h004, 32'h0,        32'h0,        1'b0, "rst_out1"});
    tbl.push_back('{1'b0, 32'h208, 32'h0,        32'h0202A510, 1'b0, "id"});
    tbl.push_back('{1'b0, 32'h200, 32'h0,        32'h0,        1'b0, "rst_status"});
    tbl.push_back('{1'b0, 32'h204, 32'h0,        32'h0,        1'b0, "rst_en"});
    tbl.push_back('{1'b0, 32'h100, 32'h0,        32'h0,        1'b0, "rst_in0"});
    tbl.push_back('{1'b0, 32'h104, 32'h0,        32'h0,        1'b0, "rst_in1"});
    tbl.push_back('{1'b0, 32'h108, 32'h0,        32'h0,        1'b1, "rd_in2_err"});
    tbl.push_back('{1'b0, 32'h008, 32'h0,        32'h0,        1'b1, "rd_out2_err"});
    tbl.push_back('{1'b1, 32'h004, 32'h12345678, 32'h0,        1'b0, "wr_out1"});
    tbl.push_back('{1'b0, 32'h004, 32'h0,        32'h12345678, 1'b0, "rb_out1"});
    tbl.push_back('{1'b1, 32'h100, 32'hDEADBEEF, 32'h0,        1'b1, "wr_in0_err"});
    tbl.push_back('{1'b1, 32'h00C, 32'h0BADF00D, 32'h0,        1'b1, "wr_out3_err"});
    tbl.push_back('{1'b1, 32'h002, 32'h0BADF00D, 32'h0,        1'b1, "wr_unalign_err"});
    tbl.push_back('{1'b1, 32'h300, 32'h0BADF00D, 32'h0,        1'b1, "wr_unmap_err"});
    tbl.push_back('{1'b1, 32'h208, 32'h0BADF00D, 32'h0,        1'b1, "wr_id_err"});
    tbl.push_back('{1'b0, 32'h300, 32'h0,        32'h0,        1'b1, "rd_unmap_err"});
    tbl.push_back('{1'b0, 32'h006, 32'h0,        32'h0,        1'b1, "rd_unalign_err"});
    tbl.push_back('{1'b0, 32'h1000, 32'h0,       32'h0,        1'b1, "rd_above_win"});
    tbl.push_back('{1'b0, 32'hFFFFFFFC, 32'h0,   32'h0,        1'b1, "rd_below_base"});
    tbl.push_back('{1'b0, 32'h20C, 32'h0,        32'h0,        1'b1, "rd_20c_err"});
    tbl.push_back('{1'b0, 32'h000, 32'h0,        32'hFF00FF00, 1'b0, "out0_kept"});
    tbl.push_back('{1'b0, 32'h004, 32'h0,        32'h12345678, 1'b0, "out1_kept"});
    tbl.push_back('{1'b0, 32'h100, 32'h0,        32'h0,        1'b0, "in0_kept"});
    tbl.push_back('{1'b1, 32'h204, 32'hFFFFFFFF, 32'h0,        1'b0, "wr_en_all"});
    tbl.push_back('{1'b0, 32'h204, 32'h0,        32'h3,        1'b0, "rd_en_mask"});
    tbl.push_back('{1'b1, 32'h204, 32'h0,        32'h0,        1'b0, "wr_en_zero"});
    tbl.push_back('{1'b0, 32'h204, 32'h0,        32'h0,        1'b0, "rd_en_zero"});
    tbl.push_back('{1'b1, 32'h000, 32'hAABBCCDD, 32'h0,        1'b0, "wr_out0"});
    tbl.push_back('{1'b0, 32'h000, 32'h0,        32'hAABBCCDD, 1'b0, "rb_out0"});

    Prst = 1'b1;
    in_data = '0;
    bus.Psel = 1'b0; bus.Penable = 1'b0; bus.Pwrite = 1'b0;
    bus.Paddr = '0; bus.Pwdata = '0;
    repeat (3) @(posedge Pclk);
    #1;
    Prst = 1'b0;
    chk("rst_irq", {31'b0, irq}, 32'h0);
    chk("rst_slverr", {31'b0, bus.Pslverr}, 32'h0);
    chk("pready", {31'b0, bus.Pready}, 32'h1);

    for (int v = 0; v < tbl.size(); v++) begin
      xfer(tbl[v].wr, tbl[v].off, tbl[v].wdata, rd, er);
      chk({tbl[v].name, "_rdata"}, rd, tbl[v].exp_rd);
      chk({tbl[v].name, "_err"}, {31'b0, er}, {31'b0, tbl[v].exp_err});
    end

    // Output port follows the register the cycle after the access phase.
    xfer(1'b1, 32'h004, 32'h0F0F0F0F, rd, er);
    chk("out_data_hi", out_data[63:32], 32'h0F0F0F0F);
    chk("out_data_lo", out_data[31:0], 32'hAABBCCDD);

    // Debounce latency: ch0 0 -> A5 visible after edge 18.
    @(posedge Pclk); #1;
    in_data[31:0] = 32'hA5;
    bus.Psel = 1'b1; bus.Pwrite = 1'b0; bus.Penable = 1'b0; bus.Paddr = BASE + 32'h100;
    for (int k = 1; k <= 19; k++) begin
      @(posedge Pclk); #1;
      chk($sformatf("db_in0_c%0d", k), bus.Prdata, (k >= 18) ? 32'hA5 : 32'h0);
    end
    bus.Psel = 1'b0;
    xfer(1'b0, 32'h200, 32'h0, rd, er);
    chk("db_status", rd, 32'h1);
    chk("db_irq_masked", {31'b0, irq}, 32'h0);

    // Return ch0 to 0, then a 5-cycle A5 pulse must not qualify.
    in_data[31:0] = 32'h0;
    repeat (25) @(posedge Pclk);
    #1;
    in_data[31:0] = 32'hA5;
    repeat (5) @(posedge Pclk);
    #1;
    in_data[31:0] = 32'h0;
    repeat (30) @(posedge Pclk);
    xfer(1'b0, 32'h100, 32'h0, rd, er);
    chk("pulse_rejected", rd, 32'h0);

    // ch1 changes 0->1 then 1->2 mid-count: count keeps running, takes 2.
    @(posedge Pclk); #1;
    in_data[63:32] = 32'h1;
    bus.Psel = 1'b1; bus.Pwrite = 1'b0; bus.Penable = 1'b0; bus.Paddr = BASE + 32'h104;
    for (int k = 1; k <= 18; k++) begin
      @(posedge Pclk); #1;
      if (k == 5) in_data[63:32] = 32'h2;
      if (k == 17) chk("chg_in1_c17", bus.Prdata, 32'h0);
      if (k == 18) chk("chg_in1_c18", bus.Prdata, 32'h2);
    end
    bus.Psel = 1'b0;

    // Interrupt raise with INT_EN=1.
    xfer(1'b1, 32'h200, 32'h3, rd, er);
    xfer(1'b0, 32'h200, 32'h0, rd, er);
    chk("w1c_all", rd, 32'h0);
    xfer(1'b1, 32'h204, 32'h1, rd, er);
    @(posedge Pclk); #1;
    in_data[31:0] = 32'h3C;
    bus.Psel = 1'b1; bus.Pwrite = 1'b0; bus.Penable = 1'b0; bus.Paddr = BASE + 32'h200;
    for (int k = 1; k <= 19; k++) begin
      @(posedge Pclk); #1;
      if (k == 17) chk("int_st_c17", bus.Prdata, 32'h0);
      if (k == 18) begin
        chk("int_st_c18", bus.Prdata, 32'h1);
        chk("int_irq_c18", {31'b0, irq}, 32'h0);
      end
      if (k == 19) chk("int_irq_c19", {31'b0, irq}, 32'h1);
    end
    bus.Psel = 1'b0;
    xfer(1'b1, 32'h200, 32'h1, rd, er);
    xfer(1'b0, 32'h200, 32'h0, rd, er);
    chk("w1c_st", rd, 32'h0);
    chk("w1c_irq", {31'b0, irq}, 32'h0);

    // W1C committing on the same edge as a new chg[0]: set wins.
    @(posedge Pclk); #1;
    in_data[31:0] = 32'h0;
    for (int k = 1; k <= 18; k++) begin
      @(posedge Pclk); #1;
      if (k == 16) begin
        bus.Psel = 1'b1; bus.Pwrite = 1'b1; bus.Penable = 1'b0;
        bus.Paddr = BASE + 32'h200; bus.Pwdata = 32'h1;
      end
      if (k == 17) bus.Penable = 1'b1;
      if (k == 18) begin
        bus.Psel = 1'b0; bus.Penable = 1'b0; bus.Pwrite = 1'b0;
      end
    end
    xfer(1'b0, 32'h200, 32'h0, rd, er);
    chk("set_wins", rd, 32'h1);
    chk("set_wins_irq", {31'b0, irq}, 32'h1);

    // Enabling with a pending status bit raises irq one cycle later.
    xfer(1'b1, 32'h204, 32'h0, rd, er);
    @(posedge Pclk); #1;
    chk("en_off_irq", {31'b0, irq}, 32'h0);
    xfer(1'b1, 32'h204, 32'h1, rd, er);
    chk("en_on_irq_c0", {31'b0, irq}, 32'h0);
    @(posedge Pclk); #1;
    chk("en_on_irq_c1", {31'b0, irq}, 32'h1);

    // Async reset during a write access to OUT[0].
    @(posedge Pclk); #1;
    bus.Psel = 1'b1; bus.Pwrite = 1'b1; bus.Penable = 1'b0;
    bus.Paddr = BASE; bus.Pwdata = 32'h11111111;
    @(posedge Pclk); #1;
    bus.Penable = 1'b1;
    #2;
    Prst = 1'b1;
    #1;
    chk("arst_out0", out_data[31:0], 32'hFF00FF00);
    chk("arst_out1", out_data[63:32], 32'h0);
    chk("arst_irq", {31'b0, irq}, 32'h0);
    @(posedge Pclk); #1;
    bus.Psel = 1'b0; bus.Penable = 1'b0; bus.Pwrite = 1'b0;
    Prst = 1'b0;
    xfer(1'b0, 32'h000, 32'h0, rd, er);
    chk("arst_no_commit", rd, 32'hFF00FF00);
    xfer(1'b0, 32'h204, 32'h0, rd, er);
    chk("arst_en", rd, 32'h0);

    // ch1 held at 2 through reset qualifies afterwards; irq stays masked.
    repeat (25) @(posedge Pclk);
    xfer(1'b0, 32'h104, 32'h0, rd, er);
    chk("post_rst_in1", rd, 32'h2);
    xfer(1'b0, 32'h200, 32'h0, rd, er);
    chk("post_rst_status", rd, 32'h2);
    chk("post_rst_irq", {31'b0, irq}, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
